// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_load,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_src
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR, R_EXEC,
    R_WB, BEQ, ADDI_EXEC, SLTI_EXEC, I_WB, JUMP
  } state_t;
  state_t state, state_n, cur;
  logic [5:0] op_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      op_q  <= 6'b000000;
    end else begin
      state <= state_n;
      if (state == DECODE) op_q <= opcode;
    end
  end
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:     state_n = DECODE;
      DECODE:    case (opcode)
                   6'b000000:            state_n = R_EXEC;
                   6'b100011, 6'b101011: state_n = MEM_ADDR;
                   6'b000100:            state_n = BEQ;
                   6'b001000:            state_n = ADDI_EXEC;
                   6'b001010:            state_n = SLTI_EXEC;
                   6'b000010:            state_n = JUMP;
                   default:              state_n = FETCH;
                 endcase
      MEM_ADDR:  state_n = (op_q == 6'b100011) ? MEM_RD : MEM_WR;
      MEM_RD:    state_n = LOAD_WB;
      R_EXEC:    state_n = R_WB;
      ADDI_EXEC: state_n = I_WB;
      SLTI_EXEC: state_n = I_WB;
      default:   state_n = FETCH;
    endcase
  end
  // Outputs show FETCH while reset is held, so any in-flight write is dropped at once
  assign cur = rst ? FETCH : state;
  always_comb begin
    pc_load    = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    pc_src     = 2'b00;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_load   = 1'b1;
      end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        pc_src    = 2'b01;
        pc_load   = zero;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      SLTI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop     = 2'b11;
      end
      I_WB:      reg_write = 1'b1;
      JUMP: begin
        pc_src  = 2'b10;
        pc_load = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed per-cycle checks of the controller output vector
module tb_mips_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
  logic       pc_load, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] reg_dst, alu_src_b, aluop, pc_src;
  int tests = 0;
  int fails = 0;
  // {pc_load,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,aluop,pc_src}
  localparam logic [15:0] V_FETCH = 16'hA810, V_DECODE = 16'h0030, V_MADDR = 16'h0060,
    V_MRD = 16'h6000, V_LWB = 16'h0180, V_MWR = 16'h5000, V_REX = 16'h0048,
    V_RWB = 16'h0280, V_BEQ0 = 16'h0045, V_BEQ1 = 16'h8045, V_ADDI = 16'h0060,
    V_SLTI = 16'h006C, V_IWB = 16'h0080, V_JUMP = 16'h8002;
  logic [15:0] vec;
  assign vec = {pc_load, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, aluop, pc_src};
  mips_multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .pc_load(pc_load), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .pc_src(pc_src)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [15:0] exp);
    chk(tag, vec, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk); #1;
    chk("rst_hold", vec, V_FETCH);
    @(posedge clk); #1;
    rst = 1'b0;
    opcode = 6'b100011;
    step("rst_fetch", V_FETCH);
    step("lw_decode", V_DECODE);
    opcode = 6'b101011;
    step("lw_maddr", V_MADDR);
    step("lw_mrd", V_MRD);
    step("lw_wb", V_LWB);
    opcode = 6'b000100;
    zero = 1'b1;
    step("beq1_fetch", V_FETCH);
    step("beq1_decode", V_DECODE);
    step("beq1_exec", V_BEQ1);
    zero = 1'b0;
    step("beq0_fetch", V_FETCH);
    step("beq0_decode", V_DECODE);
    step("beq0_exec", V_BEQ0);
    opcode = 6'b001010;
    step("slti_fetch", V_FETCH);
    step("slti_decode", V_DECODE);
    step("slti_exec", V_SLTI);
    step("slti_wb", V_IWB);
    opcode = 6'b001000;
    step("addi_fetch", V_FETCH);
    step("addi_decode", V_DECODE);
    step("addi_exec", V_ADDI);
    step("addi_wb", V_IWB);
    opcode = 6'b000000;
    step("r_fetch", V_FETCH);
    step("r_decode", V_DECODE);
    step("r_exec", V_REX);
    step("r_wb", V_RWB);
    opcode = 6'b000010;
    step("j_fetch", V_FETCH);
    step("j_decode", V_DECODE);
    step("j_exec", V_JUMP);
    opcode = 6'b111111;
    step("ill_fetch", V_FETCH);
    step("ill_decode", V_DECODE);
    opcode = 6'b101011;
    step("sw_fetch", V_FETCH);
    step("sw_decode", V_DECODE);
    opcode = 6'b100011;
    step("sw_maddr", V_MADDR);
    chk("sw_mwr", vec, V_MWR);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    opcode = 6'b111111;
    step("sw_rst_fetch", V_FETCH);
    step("post_rst_decode", V_DECODE);
    step("post_rst_fetch", V_FETCH);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
